// File: rtl/net_pkg.sv
// Shared network types: flit width, port numbering and small elaboration helpers.
// Port order is local, west, east, north, south (index 0..4).
package net_pkg;
  localparam int DW      = 16;
  localparam int N_PORTS = 5;

  localparam int P_LOCAL = 0;
  localparam int P_WEST  = 1;
  localparam int P_EAST  = 2;
  localparam int P_NORTH = 3;
  localparam int P_SOUTH = 4;

  typedef logic [DW-1:0] flit_t;

  function automatic int onehot_idx(input logic [0:N_PORTS-1] v);
    int idx;
    idx = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction
endpackage

// File: rtl/network_fifo.sv
// Generic synchronous FIFO; FWFT=1 shows the head combinationally the cycle after its write.
// Writes are dropped when full and reads when empty, so callers gate on full_o/empty_o.
module network_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter bit FWFT  = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_fire, rd_fire;

  // DEPTH is a power of two, so the count MSB alone means full.
  assign full_o  = cnt_q[AW];
  assign empty_o = (cnt_q == '0);
  assign wr_fire = wr_en_i & ~full_o;
  assign rd_fire = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  if (FWFT) begin : g_fwft
    assign rd_data_o = mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [DW-1:0] rd_data_q, rd_data_d;
    assign rd_data_d = rd_fire ? mem_q[rd_ptr_q] : rd_data_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
    end
    assign rd_data_o = rd_data_q;
  end
endmodule

// File: rtl/split_router.sv
// Multicast fork: buffers input_sel, copies each flit to every output_mask port; accept-to-valid_o 2 edges.
// ready_o follows FIFO full; a flit pops only once every masked output slot has loaded it.
module split_router
  import net_pkg::*;
#(
  parameter logic [0:N_PORTS-1] input_sel   = 5'b10000,
  parameter logic [0:N_PORTS-1] output_mask = 5'b01000,
  parameter int                 FIFO_DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [0:N_PORTS-1][DW-1:0]  data_i,
  input  logic [0:N_PORTS-1]          valid_i,
  output logic [0:N_PORTS-1]          ready_o,
  output logic [0:N_PORTS-1][DW-1:0]  data_o,
  output logic [0:N_PORTS-1]          valid_o,
  input  logic [0:N_PORTS-1]          ready_i
);
  localparam int SEL = onehot_idx(input_sel);

  if ($countones(input_sel) != 1) begin : g_bad_sel
    $error("split_router: input_sel must be one-hot");
  end
  if (output_mask == '0) begin : g_bad_mask
    $error("split_router: output_mask must be non-zero");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("split_router: FIFO_DEPTH must be a power of two");
  end

  logic                       fifo_full, fifo_empty, wr_en, retire;
  flit_t                      head;
  logic [0:N_PORTS-1]         done_q, done_d, load, free;
  logic [0:N_PORTS-1]         out_vld_q, out_vld_d;
  logic [0:N_PORTS-1][DW-1:0] out_data_q, out_data_d;
  logic                       unused_in;

  assign unused_in = ^{data_i, valid_i};

  always_comb begin
    ready_o      = '0;
    ready_o[SEL] = ~rst_i & ~fifo_full;
  end
  assign wr_en = valid_i[SEL] & ready_o[SEL];

  network_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH), .FWFT(1'b1)) u_in_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i (data_i[SEL]),
    .full_o    (fifo_full),
    .rd_en_i   (retire),
    .rd_data_o (head),
    .empty_o   (fifo_empty)
  );

  // done tracks which outputs already hold the current head so none sees it twice.
  always_comb begin
    free       = ~out_vld_q | ready_i;
    load       = output_mask & ~done_q & free & {N_PORTS{~fifo_empty}};
    retire     = ~fifo_empty & ((done_q | load) == output_mask);
    done_d     = retire ? '0 : (done_q | load);
    out_vld_d  = load | (out_vld_q & ~ready_i);
    out_data_d = out_data_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (load[i]) out_data_d[i] = head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q     <= '0;
      out_vld_q  <= '0;
      out_data_q <= '0;
    end else begin
      done_q     <= done_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    valid_o = out_vld_q & output_mask & {N_PORTS{~rst_i}};
    data_o  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (output_mask[i]) data_o[i] = out_data_q[i];
    end
  end
endmodule

// File: tb/tb_split_router.sv
// Bench for split_router: local input, multicast to west/east/north, scoreboard per output.
module tb_split_router;
  import net_pkg::*;

  localparam logic [0:N_PORTS-1] SEL  = 5'b10000;
  localparam logic [0:N_PORTS-1] MASK = 5'b01110;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic [0:N_PORTS-1][DW-1:0] data_i  = '0;
  logic [0:N_PORTS-1]         valid_i = '0;
  logic [0:N_PORTS-1]         ready_o;
  logic [0:N_PORTS-1][DW-1:0] data_o;
  logic [0:N_PORTS-1]         valid_o;
  logic [0:N_PORTS-1]         ready_i = '1;

  split_router #(.input_sel(SEL), .output_mask(MASK), .FIFO_DEPTH(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] dat;
    int            cyc;
  } exp_t;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   chk_lat = 1'b0;
  int   acc_cnt = 0;
  int   xfer_cnt [N_PORTS];
  exp_t exp_q    [N_PORTS][$];

  initial begin
    for (int i = 0; i < N_PORTS; i++) xfer_cnt[i] = 0;
  end

  // Reference model: every accepted flit must reach each masked output exactly once, in order.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (rst_i) begin
      for (int i = 0; i < N_PORTS; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (!MASK[i]) begin
          vectors++;
          if (valid_o[i] !== 1'b0 || data_o[i] !== '0) begin
            errors++;
            $display("FAIL unmasked_port%0d: valid=%b data=%h, required 0/0", i, valid_o[i], data_o[i]);
          end
        end else if (valid_o[i] && ready_i[i]) begin
          xfer_cnt[i]++;
          vectors++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL dup_port%0d: got %h with nothing outstanding", i, data_o[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (data_o[i] !== e.dat) begin
              errors++;
              $display("FAIL order_port%0d: got %h, required %h", i, data_o[i], e.dat);
            end
            if (chk_lat) begin
              vectors++;
              if (cyc - e.cyc != 2) begin
                errors++;
                $display("FAIL latency_port%0d: got %0d cycles, required 2", i, cyc - e.cyc);
              end
            end
          end
        end
      end
      if (valid_i[P_LOCAL] && ready_o[P_LOCAL]) begin
        acc_cnt++;
        for (int i = 0; i < N_PORTS; i++) begin
          if (MASK[i]) exp_q[i].push_back('{dat: data_i[P_LOCAL], cyc: cyc});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    valid_i = '0;
    data_i  = '0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int pend;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      #1;
      pend = 0;
      for (int i = 0; i < N_PORTS; i++) pend += exp_q[i].size();
      if (pend == 0 && valid_o == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    ready_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (ready_o !== '0 || valid_o !== '0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h, required all 0", ready_o, valid_o, data_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (ready_o !== 5'b10000 || valid_o !== '0) begin
      errors++;
      $display("FAIL after_reset: ready=%b valid=%b, required 10000/00000", ready_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int base [N_PORTS];
    bit ok;
    base    = xfer_cnt;
    ready_i = '1;
    chk_lat = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      valid_i[P_LOCAL] = 1'b1;
      data_i[P_LOCAL]  = DW'(32'hA0 + k);
    end
    @(posedge clk_i); #1;
    idle();
    wait_drain(20, ok);
    chk_lat = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain: outputs did not drain, required drained");
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] - base[i] != 4) begin
        errors++;
        $display("FAIL b2b_count_port%0d: got %0d, required 4", i, xfer_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_partial_stall();
    int base [N_PORTS];
    bit ok;
    base    = xfer_cnt;
    ready_i = 5'b11011;
    @(posedge clk_i); #1;
    valid_i[P_LOCAL] = 1'b1;
    data_i[P_LOCAL]  = 16'h00B0;
    @(posedge clk_i); #1;
    data_i[P_LOCAL]  = 16'h00B1;
    @(posedge clk_i); #1;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 5'b00100 || data_o[P_EAST] !== 16'h00B0) begin
      errors++;
      $display("FAIL stall_hold: valid=%b east=%h, required 00100/00b0", valid_o, data_o[P_EAST]);
    end
    @(posedge clk_i); #1;
    ready_i = '1;
    wait_drain(20, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_drain: outputs did not drain, required drained");
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] - base[i] != 2) begin
        errors++;
        $display("FAIL stall_count_port%0d: got %0d, required 2", i, xfer_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_full();
    int base [N_PORTS];
    int acc;
    bit ok;
    base    = xfer_cnt;
    acc     = 0;
    ready_i = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_i); #1;
      valid_i[P_LOCAL] = 1'b1;
      data_i[P_LOCAL]  = DW'(32'h0D00 + acc);
      @(negedge clk_i);
      if (ready_o[P_LOCAL]) acc++;
    end
    vectors++;
    if (acc != 9 || ready_o[P_LOCAL] !== 1'b0) begin
      errors++;
      $display("FAIL full_capacity: accepted %0d ready=%b, required 9/0", acc, ready_o[P_LOCAL]);
    end
    ready_i = '1;
    for (int c = 0; c < 10 && acc < 10; c++) begin
      @(posedge clk_i); #1;
      data_i[P_LOCAL] = DW'(32'h0D00 + acc);
      @(negedge clk_i);
      if (ready_o[P_LOCAL]) acc++;
    end
    @(posedge clk_i); #1;
    idle();
    vectors++;
    if (acc != 10) begin
      errors++;
      $display("FAIL full_release: accepted %0d, required 10", acc);
    end
    wait_drain(40, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL full_drain: outputs did not drain, required drained");
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] - base[i] != 10) begin
        errors++;
        $display("FAIL full_count_port%0d: got %0d, required 10", i, xfer_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_unselected();
    int base [N_PORTS];
    base    = xfer_cnt;
    ready_i = '1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      valid_i = 5'b01111;
      for (int i = 1; i < N_PORTS; i++) data_i[i] = 16'h00FF;
      @(negedge clk_i);
      vectors++;
      if ((ready_o & 5'b01111) !== 5'b00000 || valid_o !== '0) begin
        errors++;
        $display("FAIL unselected: ready=%b valid=%b, required x0000/00000", ready_o, valid_o);
      end
    end
    @(posedge clk_i); #1;
    idle();
    repeat (3) @(negedge clk_i);
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] != base[i]) begin
        errors++;
        $display("FAIL unselected_emit_port%0d: got %0d transfers, required 0", i, xfer_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base [N_PORTS];
    bit ok;
    ready_i = 5'b11011;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      valid_i[P_LOCAL] = 1'b1;
      data_i[P_LOCAL]  = DW'(32'hE0 + k);
    end
    @(posedge clk_i); #1;
    idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (valid_o !== '0 || ready_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_during: valid=%b ready=%b, required 00000/00000", valid_o, ready_o);
    end
    @(posedge clk_i); #1;
    rst_i   = 1'b0;
    ready_i = '1;
    @(negedge clk_i);
    vectors++;
    if (valid_o !== '0 || ready_o !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset_after: valid=%b ready=%b, required 00000/10000", valid_o, ready_o);
    end
    base    = xfer_cnt;
    chk_lat = 1'b1;
    @(posedge clk_i); #1;
    valid_i[P_LOCAL] = 1'b1;
    data_i[P_LOCAL]  = 16'h00C0;
    @(posedge clk_i); #1;
    idle();
    wait_drain(20, ok);
    chk_lat = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reset_drain: outputs did not drain, required drained");
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] - base[i] != 1) begin
        errors++;
        $display("FAIL mid_reset_count_port%0d: got %0d, required 1", i, xfer_cnt[i] - base[i]);
      end
    end
  endtask

  task automatic test_random();
    int base [N_PORTS];
    int acc0;
    bit ok;
    base = xfer_cnt;
    acc0 = acc_cnt;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk_i); #1;
      valid_i = N_PORTS'($urandom);
      for (int i = 0; i < N_PORTS; i++) begin
        data_i[i]  = DW'($urandom);
        ready_i[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk_i); #1;
    idle();
    ready_i = '1;
    wait_drain(40, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL random_drain: outputs did not drain, required drained");
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (xfer_cnt[i] - base[i] != acc_cnt - acc0) begin
        errors++;
        $display("FAIL random_count_port%0d: got %0d, required %0d", i, xfer_cnt[i] - base[i], acc_cnt - acc0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_stall();
    test_full();
    test_unselected();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
